// File: rtl/deal_arbiter_pkg.sv
// deal_arbiter_pkg: shared states, deck/bust limits and card-rank values for the deal arbiter.
package deal_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, INIT_DEAL, ARB, FETCH, UPDATE} state_e;
    localparam logic [6:0] DECK_DEPTH = 7'd104;
    localparam logic [4:0] BUST_LIMIT = 5'd21;
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam logic [3:0] RANK_VALUE [13] = '{
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10
    };
    function automatic logic [3:0] rank_value(input logic [5:0] idx);
        return RANK_VALUE[idx % 6'd13];
    endfunction
endpackage

// File: rtl/deal_arbiter_deck_rom.sv
// deck_rom: fixed two-shuffle deck table (104 entries) with a one-cycle registered read port.
module deck_rom
    import deal_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic [6:0] addr_i,
    output logic [5:0] data_o
);
    localparam logic [5:0] TABLE [DECK_DEPTH] = '{
        6'd23, 6'd27, 6'd14, 6'd13, 6'd31, 6'd40, 6'd22, 6'd16, 6'd5,  6'd48, 6'd0,  6'd37, 6'd19,
        6'd44, 6'd8,  6'd29, 6'd51, 6'd2,  6'd33, 6'd11, 6'd46, 6'd25, 6'd7,  6'd39, 6'd20, 6'd3,
        6'd50, 6'd28, 6'd12, 6'd42, 6'd17, 6'd35, 6'd1,  6'd45, 6'd26, 6'd9,  6'd49, 6'd32, 6'd15,
        6'd38, 6'd4,  6'd47, 6'd21, 6'd10, 6'd43, 6'd30, 6'd6,  6'd36, 6'd24, 6'd18, 6'd41, 6'd34,
        6'd7,  6'd26, 6'd45, 6'd12, 6'd31, 6'd50, 6'd17, 6'd36, 6'd3,  6'd22, 6'd41, 6'd8,  6'd27,
        6'd46, 6'd13, 6'd32, 6'd51, 6'd18, 6'd37, 6'd4,  6'd23, 6'd42, 6'd9,  6'd28, 6'd47, 6'd14,
        6'd33, 6'd0,  6'd19, 6'd38, 6'd5,  6'd24, 6'd43, 6'd10, 6'd29, 6'd48, 6'd15, 6'd34, 6'd1,
        6'd20, 6'd39, 6'd6,  6'd25, 6'd44, 6'd11, 6'd30, 6'd49, 6'd16, 6'd35, 6'd2,  6'd21, 6'd40
    };
    logic [5:0] data_q;
    always_ff @(posedge clk_i) data_q <= TABLE[addr_i];
    assign data_o = data_q;
endmodule

// File: rtl/deal_arbiter.sv
// deal_arbiter: opening deal plus round-robin hit arbitration over the shared deck table.
// DEAL_ACE_HIGH_EN: when defined, an ace counts 11 whenever that still fits under the bust limit.
module deal_arbiter
    import deal_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       round_start,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       card_valid,
    output logic [5:0] card_index,
    output logic [3:0] card_value,
    output logic [4:0] total_p1,
    output logic [4:0] total_p2,
    output logic [1:0] bust,
    output logic       deal_busy,
    output logic [6:0] deck_ptr
);
    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d, bust_q, bust_d;
    logic [4:0] total_q [2];
    logic [4:0] total_d [2];
    logic [2:0] deal_cnt_q, deal_cnt_d;
    logic       prio_q, prio_d;
    logic [6:0] ptr_q, ptr_d;
    logic [5:0] rom_data;
    logic [1:0] elig;
    logic       owner, winner;
    logic [4:0] cur, sum;
    logic [3:0] base_val, applied_val;

    deck_rom u_deck_rom (.clk_i(clock), .addr_i(ptr_q), .data_o(rom_data));

    assign owner    = grant_q[P2];
    assign cur      = total_q[owner];
    assign base_val = rank_value(rom_data);
`ifdef DEAL_ACE_HIGH_EN
    assign applied_val = (base_val == 4'd1 && cur <= BUST_LIMIT - 5'd11) ? 4'd11 : base_val;
`else
    assign applied_val = base_val;
`endif
    assign sum    = cur + {1'b0, applied_val};
    assign elig   = req & ~bust_q;
    // prio_q names the player favoured on a tie; the last ARB winner loses it
    assign winner = (elig == 2'b11) ? prio_q : elig[P2];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        bust_d     = bust_q;
        total_d    = total_q;
        deal_cnt_d = deal_cnt_q;
        prio_d     = prio_q;
        ptr_d      = (state_q != FETCH) ? ptr_q : (ptr_q == DECK_DEPTH - 7'd1) ? 7'd0 : ptr_q + 7'd1;
        if (round_start) begin
            state_d    = INIT_DEAL;
            grant_d    = '0;
            bust_d     = '0;
            total_d    = '{default: '0};
            deal_cnt_d = '0;
            prio_d     = 1'b0;
        end else begin
            case (state_q)
                INIT_DEAL: begin
                    grant_d    = deal_cnt_q[0] ? 2'b10 : 2'b01;
                    deal_cnt_d = deal_cnt_q + 3'd1;
                    state_d    = FETCH;
                end
                ARB: if (elig != 2'b00) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    prio_d  = ~winner;
                    state_d = FETCH;
                end
                FETCH: state_d = UPDATE;
                UPDATE: begin
                    total_d[owner] = sum;
                    bust_d[owner]  = bust_q[owner] | (sum > BUST_LIMIT);
                    grant_d        = '0;
                    state_d        = (deal_cnt_q == 3'd4) ? ARB : INIT_DEAL;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            bust_q     <= '0;
            total_q    <= '{default: '0};
            deal_cnt_q <= '0;
            prio_q     <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            bust_q     <= bust_d;
            total_q    <= total_d;
            deal_cnt_q <= deal_cnt_d;
            prio_q     <= prio_d;
            ptr_q      <= ptr_d;
        end
    end

    assign grant      = grant_q;
    assign card_valid = (state_q == UPDATE) && !round_start;
    assign card_index = card_valid ? rom_data : 6'd0;
    assign card_value = card_valid ? applied_val : 4'd0;
    assign total_p1   = total_q[P1];
    assign total_p2   = total_q[P2];
    assign bust       = bust_q;
    assign deal_busy  = (state_q != IDLE) && (state_q != ARB);
    assign deck_ptr   = ptr_q;
endmodule

// File: tb/tb_deal_arbiter.sv
// tb_deal_arbiter: directed and randomized rounds/hits checked against a card-level model.
module tb_deal_arbiter;
    logic       clock = 1'b0;
    logic       reset, round_start;
    logic [1:0] req, grant, bust;
    logic       card_valid, deal_busy;
    logic [5:0] card_index;
    logic [3:0] card_value;
    logic [4:0] total_p1, total_p2;
    logic [6:0] deck_ptr;
    int         checks = 0;
    int         failures = 0;
    int         m_tot [2];
    logic [1:0] m_bust;
    int         m_ptr, m_last, abort_ptr, last_idx, last_val, last_owner;
    int         learned [104];
    int         dealt [$];
    bit         wrapped;
    int         spec_head [8] = '{23, 27, 14, 13, 31, 40, 22, 16};
`ifdef DEAL_ACE_HIGH_EN
    localparam bit ACE_HI = 1'b1;
`else
    localparam bit ACE_HI = 1'b0;
`endif

    deal_arbiter dut (
        .clock(clock), .reset(reset), .round_start(round_start), .req(req), .grant(grant),
        .card_valid(card_valid), .card_index(card_index), .card_value(card_value),
        .total_p1(total_p1), .total_p2(total_p2), .bust(bust), .deal_busy(deal_busy),
        .deck_ptr(deck_ptr)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int card_val(input int idx, input int cur);
        int r;
        r = idx % 13;
        if (r == 0) return (ACE_HI && cur + 11 <= 21) ? 11 : 1;
        return (r <= 9) ? r + 1 : 10;
    endfunction

    task automatic take_card(input int o);
        int p, v, dups, base;
        p = m_ptr;
        chk("deck_ptr_after_fetch", 32'(deck_ptr), (p + 1) % 104);
        chk("index_range", 32'(card_index < 6'd52), 1);
        if (learned[p] >= 0) chk("card_index", 32'(card_index), learned[p]);
        else begin
            dups = 0;
            base = (p / 52) * 52;
            for (int q = base; q < base + 52; q++) if (learned[q] == int'(card_index)) dups++;
            chk("deck_unique_in_shuffle", dups, 0);
            learned[p] = int'(card_index);
        end
        v = card_val(int'(card_index), m_tot[o]);
        chk("card_value", 32'(card_value), v);
        m_tot[o] += v;
        if (m_tot[o] > 21) m_bust[o] = 1'b1;
        m_ptr = (p + 1) % 104;
        dealt.push_back(int'(card_index));
        last_idx = int'(card_index);
        last_val = v;
        last_owner = o;
    endtask

    task automatic tick(input logic exp_cv, input logic [1:0] exp_gnt, input logic exp_busy);
        @(posedge clock);
        #1;
        chk("total_p1", 32'(total_p1), m_tot[0]);
        chk("total_p2", 32'(total_p2), m_tot[1]);
        chk("bust", 32'(bust), 32'(m_bust));
        chk("card_valid", 32'(card_valid), 32'(exp_cv));
        chk("grant", 32'(grant), 32'(exp_gnt));
        chk("deal_busy", 32'(deal_busy), 32'(exp_busy));
        if (card_valid && exp_cv) take_card(int'(exp_gnt[1]));
    endtask

    task automatic clear_model();
        m_tot = '{0, 0};
        m_bust = 2'b00;
        m_last = 1;
    endtask

    task automatic deal_after_pulse();
        dealt.delete();
        for (int k = 1; k <= 13; k++) begin
            if (k == 13) tick(1'b0, 2'b00, 1'b0);
            else tick(k % 3 == 0, (k % 3 == 1) ? 2'b00 : ((((k - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01), 1'b1);
            if (k == 1) round_start = 1'b0;
        end
    endtask

    task automatic start_round();
        round_start = 1'b1;
        clear_model();
        deal_after_pulse();
    endtask

    task automatic hit(input logic [1:0] pattern);
        logic [1:0] elig, g;
        int w;
        req = pattern;
        elig = pattern & ~m_bust;
        if (elig == 2'b00) begin
            repeat (3) tick(1'b0, 2'b00, 1'b0);
            return;
        end
        w = (elig == 2'b11) ? 1 - m_last : int'(elig[1]);
        m_last = w;
        g = (w == 1) ? 2'b10 : 2'b01;
        tick(1'b0, g, 1'b1);
        tick(1'b1, g, 1'b1);
        tick(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        round_start = 1'b0;
        req = 2'b00;
        m_ptr = 0;
        last_owner = -1;
        for (int i = 0; i < 104; i++) learned[i] = (i < 8) ? spec_head[i] : -1;
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_card_valid", 32'(card_valid), 0);
        chk("rst_card_index", 32'(card_index), 0);
        chk("rst_card_value", 32'(card_value), 0);
        chk("rst_total_p1", 32'(total_p1), 0);
        chk("rst_total_p2", 32'(total_p2), 0);
        chk("rst_bust", 32'(bust), 0);
        chk("rst_deal_busy", 32'(deal_busy), 0);
        chk("rst_deck_ptr", 32'(deck_ptr), 0);
        reset = 1'b0;

        start_round();
        for (int i = 0; i < 4; i++) chk("open_card", dealt[i], spec_head[i]);
        chk("open_total_p1", 32'(total_p1), 12);
        chk("open_total_p2", 32'(total_p2), ACE_HI ? 13 : 3);

        hit(2'b11);
        chk("hit1_owner", last_owner, 0);
        chk("hit1_idx", last_idx, 31);
        chk("hit1_val", last_val, 6);
        hit(2'b11);
        chk("hit2_owner", last_owner, 1);
        chk("hit2_idx", last_idx, 40);
        chk("hit2_val", last_val, 2);
        chk("hits_total_p1", 32'(total_p1), 18);
        chk("hits_total_p2", 32'(total_p2), ACE_HI ? 15 : 5);

        for (int i = 0; i < 12 && !m_bust[0]; i++) hit(2'b01);
        chk("p1_bust_flag", 32'(bust[0]), 1);
        hit(2'b01);
        last_owner = -1;
        hit(2'b11);
        chk("p2_served_after_p1_bust", last_owner, 1);
        for (int i = 0; i < 12 && !m_bust[1]; i++) hit(2'b10);
        hit(2'b11);
        chk("both_bust", 32'(bust), 3);

        round_start = 1'b1;
        clear_model();
        tick(1'b0, 2'b00, 1'b1);
        round_start = 1'b0;
        tick(1'b0, 2'b01, 1'b1);
        round_start = 1'b1;
        clear_model();
        m_ptr = (m_ptr + 1) % 104;
        abort_ptr = m_ptr;
        deal_after_pulse();
        chk("abort_resume_ptr", 32'(deck_ptr), (abort_ptr + 4) % 104);

        for (int i = 0; i < 40; i++) begin
            if (m_bust == 2'b11 || $urandom_range(0, 5) == 0) start_round();
            else hit(2'($urandom_range(0, 3)));
        end

        wrapped = 1'b0;
        for (int it = 0; it < 400 && !wrapped; it++) begin
            if (104 - m_ptr >= 4 || m_bust == 2'b11) start_round();
            else hit(2'b11);
            wrapped = (m_ptr == 0);
        end
        chk("wrap_reached", 32'(wrapped), 1);
        chk("wrap_deck_ptr", 32'(deck_ptr), 0);
        start_round();
        chk("wrap_first_card", dealt[0], 23);

        round_start = 1'b1;
        clear_model();
        tick(1'b0, 2'b00, 1'b1);
        round_start = 1'b0;
        tick(1'b0, 2'b01, 1'b1);
        tick(1'b1, 2'b01, 1'b1);
        reset = 1'b1;
        clear_model();
        m_ptr = 0;
        tick(1'b0, 2'b00, 1'b0);
        chk("mid_rst_deck_ptr", 32'(deck_ptr), 0);
        chk("mid_rst_card_index", 32'(card_index), 0);
        chk("mid_rst_card_value", 32'(card_value), 0);
        reset = 1'b0;
        req = 2'b11;
        repeat (3) tick(1'b0, 2'b00, 1'b0);
        req = 2'b00;
        start_round();
        chk("post_rst_first_card", dealt[0], 23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/deal_arbiter.md
# deal_arbiter

Sequences and shares the single shuffled card source between the two blackjack players. Runs the four-card opening deal on each round start, then arbitrates hit requests round-robin. Each draw goes through a one-request/one-card handshake. Converts each drawn deck index to a blackjack value and keeps each player's running total and bust flag. Sits between the player-input/state-machine logic and the deck table; it is the only reader of the deck.

## Interface
- `DECK_DEPTH`, 104: deck-table entries, i.e. two 52-card shuffles played back to back.
- `BUST_LIMIT`, 21: a total strictly greater than this sets the bust flag.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `round_start`  in  1  one-cycle pulse that clears the totals and begins the opening deal.
- `req`  in  2  level-sensitive hit requests; bit0 is P1, bit1 is P2.
- `grant`  out  2  one-hot, or zero; marks the player owning the current draw.
- `card_valid`  out  1  one-cycle pulse; card outputs are valid in this cycle.
- `card_index`  out  6  drawn deck index, 0..51.
- `card_value`  out  4  blackjack value of the drawn card, 1..11.
- `total_p1`, `total_p2`  out  5 each  running totals.
- `bust`  out  2  per-player flag, set when that total exceeds `BUST_LIMIT`.
- `deal_busy`  out  1  high in every state except IDLE and ARB.
- `deck_ptr`  out  7  next deck-table address.

## Operation
- States:
  - IDLE: after reset; waits for `round_start`.
  - INIT_DEAL: issues the fixed order P1, P2, P1, P2.
  - ARB: waits for and selects a hit request.
  - FETCH: reads the deck table.
  - UPDATE: presents the card and updates the owner's total.
- Transitions:
  - IDLE→INIT_DEAL on `round_start`.
  - INIT_DEAL→FETCH, with `grant` set to the next player in the opening order.
  - FETCH→UPDATE, always.
  - UPDATE→INIT_DEAL while fewer than 4 opening cards have been dealt; otherwise UPDATE→ARB.
  - ARB→FETCH when any eligible request exists.
- A request is eligible when its `req` bit is 1 and the matching `bust` bit is 0.
- Round-robin: the most recent ARB winner has lowest priority. After reset, or after an opening deal, P1 has priority.
- Value mapping: rank = index mod 13.
  - Rank 0 (ace) maps to 1.
  - Ranks 1..9 map to 2..10.
  - Ranks 10..12 map to 10.
- Width: a total is at most 21 before a draw, and the largest addable value is 10 (an ace adds 11 only if the result fits). The maximum total is therefore 31, and 5 bits never overflow. No saturation logic.
- `deck_ptr` increments once per FETCH and wraps from `DECK_DEPTH`−1 to 0. It is not cleared by `round_start`, so the deck continues across rounds.
- Requests do not queue. A requester holding `req` high after its `card_valid` receives another card if it wins the next arbitration.
- Boundary cases:
  - `round_start` in any non-IDLE state aborts the current draw (no `card_valid`) and clears totals, `bust` and `grant`. Next state is INIT_DEAL. `deck_ptr` keeps any increment already made.
  - `round_start` in the same cycle as an UPDATE: the abort wins, and the pending total update is discarded.
  - Both players bust: ARB idles until `round_start`.
- `reset` clears all state. Every output is 0 and the state is IDLE.

## Timing
- Deck-table read has a one-cycle registered latency: address presented in FETCH, data used in UPDATE.
- A hit request seen by ARB in cycle n gives:
  - `grant` in cycles n+1 and n+2;
  - `card_valid` in cycle n+2;
  - the updated total and `bust` from cycle n+3.
- `grant` is held constant from FETCH through UPDATE and is 0 in every other state.
- Opening deal after a `round_start` pulse in cycle n:
  - four `card_valid` pulses, in cycles n+3, n+6, n+9 and n+12;
  - ARB entered in cycle n+13.

## Configuration
- `DEAL_ACE_HIGH_EN`:
  - Defined: an ace is valued 11 when the owner's current total + 11 ≤ `BUST_LIMIT`, otherwise 1. `card_value` reports the value actually applied. An ace already counted as 11 is never later demoted.
  - Undefined: an ace is always 1 and `card_value` is never above 10.

## Structure
- Shared package holds:
  - state enum;
  - `DECK_DEPTH`;
  - `BUST_LIMIT`;
  - the 13-entry rank→value constant;
  - player index constants P1=0 and P2=1.
- One sub-module, `deck_rom`: the fixed 104-entry shuffle table with a registered read port. Its first eight entries are 23, 27, 14, 13, 31, 40, 22, 16.

## Test plan
- Reset, then `round_start`:
  - `card_index` sequence 23, 27, 14, 13, with grants P1, P2, P1, P2.
  - With `DEAL_ACE_HIGH_EN`: `total_p1`=12, `total_p2`=13.
  - Without it: 12 and 3.
- After the opening deal, hold `req`=2'b11 for two draws: grants P1 then P2, cards 31 (value 6) and 40 (value 2), giving totals 18 and 15 (macro on).
- P1 keeps hitting until its total exceeds 21: `bust[0]`=1, and P1's `req` is then ignored while P2 is still served.
- Assert `round_start` during FETCH: no `card_valid`, totals 0, and the opening deal restarts from the incremented `deck_ptr`.
- Run 104 draws: `deck_ptr` wraps to 0 and the next `card_index` is 23.
- Assert `reset` mid-UPDATE: next cycle, every output is 0 and the state is IDLE.
